// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_pkg
//  Description : Shared core types for the fetch stage: sequencer states,
//                opcode type, fetch fault causes and the NOP instruction.
//  Revision    : 1.0  initial release
// ============================================================================
package instr_fetch_pkg;

    // Sequencer states of the multi-cycle core
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    // Major opcode field, instruction bits [6:0]
    typedef logic [6:0] opcode_t;

    // Reason the last fetch produced a substituted NOP
    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_BUS_ERR  = 2'd2,
        FAULT_TIMEOUT  = 2'd3
    } fetch_fault_t;

    // addi x0,x0,0
    localparam logic [31:0] c_NOP_INSN = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/sm_intf.sv
`default_nettype none
// ============================================================================
//  Module      : sm_intf
//  Description : Handshake between a pipeline-stage unit and the core
//                sequencer (state_machine).
//  Revision    : 1.0  initial release
// ============================================================================
interface sm_intf;
    logic                     state_finish;
    instr_fetch_pkg::opcode_t opcode;
    instr_fetch_pkg::state_t  now_state;
    instr_fetch_pkg::state_t  now_state_d1;
    instr_fetch_pkg::state_t  next_state;

    modport master (
        output state_finish,
        output opcode,
        input  now_state,
        input  now_state_d1,
        input  next_state
    );

    modport slave (
        input  state_finish,
        input  opcode,
        output now_state,
        output now_state_d1,
        output next_state
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction-fetch stage. Issues one word read per FETCH
//                visit, latches the instruction and pulses state_finish.
//                Misaligned PCs, bus errors and timeouts substitute a NOP.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] NOP_INSN = c_NOP_INSN
) (
    input  logic              clk,
    input  logic              rst,
    sm_intf.master            sm_if,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    input  logic              mem_resp_err,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              fault_o,
    output fetch_fault_t      fault_cause_o
);

    localparam int                CNT_W        = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  c_TO_MAX     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  c_TO_LAST    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } ifetch_state_t;

    ifetch_state_t     r_state;
    ifetch_state_t     w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_fault;
    fetch_fault_t      r_cause;

    logic w_start;
    logic w_misalign;
    logic w_timeout;
    logic w_unused;

    assign w_start    = (sm_if.now_state == FETCH);
    assign w_misalign = (pc_i[1:0] != 2'b00);
    // Last WAIT cycle: the counter reaches TIMEOUT on this edge
    assign w_timeout  = (r_cnt == c_TO_LAST);

    // Sequencer history/lookahead are not needed by this stage
    assign w_unused = ^{sm_if.now_state_d1, sm_if.next_state};

    assign mem_req_addr  = r_addr;
    assign instr_o       = r_instr;
    assign pc_o          = r_pc;
    assign fault_o       = r_fault;
    assign fault_cause_o = r_cause;

    // Next-state decode and per-state outputs
    always_comb begin
        w_next_state       = r_state;
        mem_req_valid      = 1'b0;
        sm_if.state_finish = 1'b0;
        sm_if.opcode       = r_instr[6:0];
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = w_misalign ? DONE : REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                sm_if.state_finish = 1'b1;
                w_next_state       = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register, timeout counter and result latches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_pc    <= '0;
            r_instr <= NOP_INSN;
            r_fault <= 1'b0;
            r_cause <= FAULT_NONE;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_pc   <= pc_i;
                        r_addr <= {pc_i[ADDR_W-1:2], 2'b00};
                        if (w_misalign) begin
                            r_instr <= NOP_INSN;
                            r_fault <= 1'b1;
                            r_cause <= FAULT_MISALIGN;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (mem_resp_err) begin
                            r_instr <= NOP_INSN;
                            r_fault <= 1'b1;
                            r_cause <= FAULT_BUS_ERR;
                        end else begin
                            r_instr <= mem_resp_data;
                            r_fault <= 1'b0;
                            r_cause <= FAULT_NONE;
                        end
                    end else begin
                        // Saturating: never wraps back into a fresh wait window
                        if (r_cnt != c_TO_MAX) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_timeout) begin
                            r_instr <= NOP_INSN;
                            r_fault <= 1'b1;
                            r_cause <= FAULT_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pc_i;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [31:0]  mem_resp_data;
    logic         mem_resp_err;
    logic [31:0]  instr_o;
    logic [31:0]  pc_o;
    logic         fault_o;
    fetch_fault_t fault_cause_o;

    int errors = 0;
    int checks = 0;

    sm_intf u_sm ();

    always #5 clk = ~clk;

    always_ff @(posedge clk) u_sm.now_state_d1 <= u_sm.now_state;

    instr_fetch #(
        .ADDR_W   (32),
        .TIMEOUT  (4),
        .NOP_INSN (32'h0000_0013)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .sm_if          (u_sm),
        .pc_i           (pc_i),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .fault_o        (fault_o),
        .fault_cause_o  (fault_cause_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_state(input state_t s);
        u_sm.now_state  = s;
        u_sm.next_state = s;
    endtask

    // Drives one fetch with a simple memory model. Returns in the cycle where
    // state_finish is seen; cycles counts from the first FETCH cycle (=1), or
    // -1 if no pulse arrived within the budget.
    task automatic run_fetch(input logic [31:0] pc, input int stall, input int lat,
                             input logic [31:0] data, input logic err,
                             output int cycles, output bit req_seen, output bit addr_ok);
        int stall_left;
        int wait_cyc;
        bit accepted;
        stall_left = stall;
        wait_cyc   = 0;
        accepted   = 1'b0;
        req_seen   = 1'b0;
        addr_ok    = 1'b1;
        cycles     = -1;
        set_state(FETCH);
        pc_i = pc;
        for (int c = 1; c <= 60; c++) begin
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            mem_req_ready  = 1'b0;
            if (u_sm.state_finish) begin
                cycles = c;
                break;
            end
            if (mem_req_valid) begin
                req_seen = 1'b1;
                if (mem_req_addr !== (pc & 32'hFFFF_FFFC)) addr_ok = 1'b0;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_ready = 1'b1;
                    accepted      = 1'b1;
                end
            end else if (accepted && lat > 0) begin
                wait_cyc++;
                if (wait_cyc == lat) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = data;
                    mem_resp_err   = err;
                end
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
    endtask

    // Sequencer leaves FETCH on the pulse edge
    task automatic leave_fetch();
        set_state(DECODE);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_state(DECODE);
        pc_i = 32'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0; mem_resp_err = 1'b0;
        repeat (3) tick();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_req_addr); end
        checks++; if (u_sm.state_finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", u_sm.state_finish); end
        checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr_o); end
        checks++; if (u_sm.opcode !== 7'h13) begin errors++; $display("FAIL reset_opcode: got %h expected 13", u_sm.opcode); end
        checks++; if (pc_o !== 32'h0 || fault_o !== 1'b0 || fault_cause_o !== FAULT_NONE) begin
            errors++; $display("FAIL reset_pc_fault: got pc=%h f=%b c=%0d expected 0/0/0", pc_o, fault_o, fault_cause_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cyc; bit rs; bit aok;
        run_fetch(32'h100, 0, 1, 32'h0050_0093, 1'b0, cyc, rs, aok);
        checks++; if (cyc != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", cyc); end
        checks++; if (u_sm.opcode !== 7'h13) begin errors++; $display("FAIL basic_opcode: got %h expected 13", u_sm.opcode); end
        checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr: got %h expected 00500093", instr_o); end
        checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL basic_pc: got %h expected 00000100", pc_o); end
        checks++; if (fault_o !== 1'b0 || fault_cause_o !== FAULT_NONE) begin
            errors++; $display("FAIL basic_fault: got f=%b c=%0d expected 0/0", fault_o, fault_cause_o); end
        leave_fetch();
        checks++; if (u_sm.state_finish !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got %b expected 0", u_sm.state_finish); end
    endtask

    task automatic test_stall();
        int cyc; bit rs; bit aok;
        run_fetch(32'h104, 3, 1, 32'h00A0_0113, 1'b0, cyc, rs, aok);
        checks++; if (cyc != 7) begin errors++; $display("FAIL stall_latency: got %0d expected 7", cyc); end
        checks++; if (aok !== 1'b1) begin errors++; $display("FAIL stall_addr_stable: got %b expected 1", aok); end
        checks++; if (instr_o !== 32'h00A0_0113) begin errors++; $display("FAIL stall_instr: got %h expected 00a00113", instr_o); end
        leave_fetch();
    endtask

    task automatic test_misalign();
        int cyc; bit rs; bit aok;
        run_fetch(32'h102, 0, 1, 32'h1111_1111, 1'b0, cyc, rs, aok);
        checks++; if (cyc != 2) begin errors++; $display("FAIL misalign_latency: got %0d expected 2", cyc); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL misalign_no_req: got %b expected 0", rs); end
        checks++; if (fault_cause_o !== FAULT_MISALIGN || fault_o !== 1'b1) begin
            errors++; $display("FAIL misalign_cause: got f=%b c=%0d expected 1/1", fault_o, fault_cause_o); end
        checks++; if (instr_o !== 32'h13 || pc_o !== 32'h102) begin
            errors++; $display("FAIL misalign_instr_pc: got %h/%h expected 00000013/00000102", instr_o, pc_o); end
        leave_fetch();
    endtask

    task automatic test_bus_err();
        int cyc; bit rs; bit aok;
        run_fetch(32'h108, 0, 2, 32'hDEAD_BEEF, 1'b1, cyc, rs, aok);
        checks++; if (cyc != 5) begin errors++; $display("FAIL buserr_latency: got %0d expected 5", cyc); end
        checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL buserr_instr: got %h expected 00000013", instr_o); end
        checks++; if (fault_cause_o !== FAULT_BUS_ERR || fault_o !== 1'b1) begin
            errors++; $display("FAIL buserr_cause: got f=%b c=%0d expected 1/2", fault_o, fault_cause_o); end
        leave_fetch();
        checks++; if (u_sm.state_finish !== 1'b0) begin errors++; $display("FAIL buserr_single_pulse: got %b expected 0", u_sm.state_finish); end
    endtask

    task automatic test_timeout();
        int cyc; bit rs; bit aok; bit extra;
        run_fetch(32'h10C, 0, 0, 32'h0, 1'b0, cyc, rs, aok);
        checks++; if (cyc != 7) begin errors++; $display("FAIL timeout_latency: got %0d expected 7", cyc); end
        checks++; if (fault_cause_o !== FAULT_TIMEOUT || instr_o !== 32'h13) begin
            errors++; $display("FAIL timeout_cause: got c=%0d i=%h expected 3/00000013", fault_cause_o, instr_o); end
        // Late response while DONE and then IDLE
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678; mem_resp_err = 1'b0;
        leave_fetch();
        extra = u_sm.state_finish;
        tick();
        mem_resp_valid = 1'b0;
        extra = extra | u_sm.state_finish;
        tick();
        checks++; if (instr_o !== 32'h13 || fault_cause_o !== FAULT_TIMEOUT || extra !== 1'b0) begin
            errors++; $display("FAIL timeout_late_resp: got i=%h c=%0d p=%b expected 00000013/3/0", instr_o, fault_cause_o, extra); end
    endtask

    task automatic test_reset_mid();
        bit pulse;
        set_state(FETCH); pc_i = 32'h200; mem_req_ready = 1'b1;
        tick();   // REQ
        tick();   // WAIT
        mem_req_ready = 1'b0;
        rst = 1'b1; set_state(DECODE);
        tick();
        checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || u_sm.state_finish !== 1'b0) begin
            errors++; $display("FAIL rstmid_bus: got v=%b a=%h p=%b expected 0/0/0", mem_req_valid, mem_req_addr, u_sm.state_finish); end
        checks++; if (instr_o !== 32'h13 || pc_o !== 32'h0 || fault_o !== 1'b0 || fault_cause_o !== FAULT_NONE) begin
            errors++; $display("FAIL rstmid_regs: got i=%h pc=%h f=%b c=%0d expected 00000013/0/0/0", instr_o, pc_o, fault_o, fault_cause_o); end
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hABCD_EF01;
        pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            mem_resp_valid = 1'b0;
            pulse = pulse | u_sm.state_finish;
        end
        checks++; if (pulse !== 1'b0 || instr_o !== 32'h13) begin
            errors++; $display("FAIL rstmid_ignored: got p=%b i=%h expected 0/00000013", pulse, instr_o); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit rs; bit aok; bit pulse;
        logic [31:0] pc; logic [31:0] data; int stall; int lat;
        for (int n = 0; n < 100; n++) begin
            pc    = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            data  = $urandom;
            stall = $urandom_range(0, 2);
            lat   = $urandom_range(1, 3);
            run_fetch(pc, stall, lat, data, 1'b0, cyc, rs, aok);
            checks++; if (cyc != 3 + stall + lat) begin
                errors++; $display("FAIL seq_latency[%0d]: got %0d expected %0d", n, cyc, 3 + stall + lat); end
            checks++; if (instr_o !== data || pc_o !== pc || fault_o !== 1'b0) begin
                errors++; $display("FAIL seq_result[%0d]: got %h/%h/%b expected %h/%h/0", n, instr_o, pc_o, fault_o, data, pc); end
            leave_fetch();
            pulse = u_sm.state_finish;
            set_state(EXECUTE);   tick(); pulse = pulse | u_sm.state_finish;
            set_state(MEMORY);    tick(); pulse = pulse | u_sm.state_finish;
            set_state(WRITEBACK); tick(); pulse = pulse | u_sm.state_finish;
            checks++; if (pulse !== 1'b0) begin
                errors++; $display("FAIL seq_extra_pulse[%0d]: got %b expected 0", n, pulse); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_misalign();
        test_bus_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
